cond_ctrl_pipe: RTL and testbench

// Carries hazard-relevant control/address fields from Decode through the E, M and W pipeline registers.

---
 rtl/cond_ctrl_pipe.sv | 101 ++++++++++
 tb/tb_cond_ctrl_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_ctrl_pipe.sv
// cond_ctrl_pipe: E/M/W control pipeline with ARM condition evaluation against the NZCV flags.
// Exposes every E/M/W-side field the hazard unit needs; FlushE turns the D->E transfer into a bubble.
module cond_ctrl_pipe #(
    parameter int          ADDR_W    = 4,
    parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              FlushE,
    input  logic [ADDR_W-1:0] RA1D,
    input  logic [ADDR_W-1:0] RA2D,
    input  logic [ADDR_W-1:0] WA3D,
    input  logic              RegWriteD,
    input  logic              MemToRegD,
    input  logic              PCSrcD,
    input  logic              BranchD,
    input  logic [1:0]        FlagWriteD,
    input  logic [3:0]        CondD,
    input  logic [3:0]        ALUFlagsE,
    output logic [ADDR_W-1:0] RA1E,
    output logic [ADDR_W-1:0] RA2E,
    output logic [ADDR_W-1:0] WA3E,
    output logic              MemToRegE,
    output logic              PCSrcE,
    output logic              BranchTakenE,
    output logic [ADDR_W-1:0] WA3M,
    output logic              RegWriteM,
    output logic              PCSrcM,
    output logic [ADDR_W-1:0] WA3W,
    output logic              RegWriteW,
    output logic              MemToRegW,
    output logic              PCSrcW
);
    localparam int E_W = 3 * ADDR_W + 10;
    localparam int M_W = ADDR_W + 3;

    logic [E_W-1:0] e_d, e_q;
    logic [M_W-1:0] m_d, m_q, w_q;
    logic [3:0]     flags_d, flags_q;
    logic [3:0]     cond_e;
    logic [1:0]     fw_e;
    logic           rw_e, pcs_e, br_e, cond_ex;
    logic           n, z, c, v, mtr_m;

    assign e_d = FlushE ? '0 : {RA1D, RA2D, WA3D, RegWriteD, MemToRegD, PCSrcD, BranchD, FlagWriteD, CondD};
    assign {RA1E, RA2E, WA3E, rw_e, MemToRegE, pcs_e, br_e, fw_e, cond_e} = e_q;
    assign {n, z, c, v} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (cond_e)
            4'h0: cond_ex = z;
            4'h1: cond_ex = !z;
            4'h2: cond_ex = c;
            4'h3: cond_ex = !c;
            4'h4: cond_ex = n;
            4'h5: cond_ex = !n;
            4'h6: cond_ex = v;
            4'h7: cond_ex = !v;
            4'h8: cond_ex = c & !z;
            4'h9: cond_ex = !c | z;
            4'hA: cond_ex = n == v;
            4'hB: cond_ex = n != v;
            4'hC: cond_ex = !z & (n == v);
            4'hD: cond_ex = z | (n != v);
            4'hE: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if (cond_ex & fw_e[1]) flags_d[3:2] = ALUFlagsE[3:2];
        if (cond_ex & fw_e[0]) flags_d[1:0] = ALUFlagsE[1:0];
    end

    // A failed condition squashes every side effect before the instruction leaves E.
    assign m_d = {WA3E, rw_e & cond_ex, MemToRegE & cond_ex, pcs_e & cond_ex};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            e_q     <= '0;
            m_q     <= '0;
            w_q     <= '0;
            flags_q <= FLAGS_RST;
        end else begin
            e_q     <= e_d;
            m_q     <= m_d;
            w_q     <= m_q;
            flags_q <= flags_d;
        end
    end

    assign PCSrcE       = pcs_e & cond_ex;
    assign BranchTakenE = br_e & cond_ex;
    assign {WA3M, RegWriteM, mtr_m, PCSrcM} = m_q;
    assign {WA3W, RegWriteW, MemToRegW, PCSrcW} = w_q;

    logic unused_mtr_m;
    assign unused_mtr_m = mtr_m;
endmodule

// File: tb/tb_cond_ctrl_pipe.sv
// tb_cond_ctrl_pipe: directed scenarios plus randomized traffic against an instruction-level pipeline model.
module tb_cond_ctrl_pipe;
    typedef struct packed {
        logic [3:0] ra1, ra2, wa3;
        logic       rw, mtr, pcs, br;
        logic [1:0] fw;
        logic [3:0] cond;
    } inst_t;

    typedef struct packed {
        logic [3:0] wa3;
        logic       rw, mtr, pcs;
    } mw_t;

    logic       Clk, Reset, FlushE;
    logic [3:0] RA1D, RA2D, WA3D, CondD, ALUFlagsE;
    logic       RegWriteD, MemToRegD, PCSrcD, BranchD;
    logic [1:0] FlagWriteD;
    logic [3:0] RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       MemToRegE, PCSrcE, BranchTakenE, RegWriteM, PCSrcM, RegWriteW, MemToRegW, PCSrcW;

    int n_vec = 0;
    int n_bad = 0;

    inst_t      me;
    mw_t        mm, mw;
    logic [3:0] mf;

    cond_ctrl_pipe dut (
        .Clk(Clk), .Reset(Reset), .FlushE(FlushE),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .RegWriteD(RegWriteD), .MemToRegD(MemToRegD), .PCSrcD(PCSrcD), .BranchD(BranchD),
        .FlagWriteD(FlagWriteD), .CondD(CondD), .ALUFlagsE(ALUFlagsE),
        .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E), .MemToRegE(MemToRegE),
        .PCSrcE(PCSrcE), .BranchTakenE(BranchTakenE),
        .WA3M(WA3M), .RegWriteM(RegWriteM), .PCSrcM(PCSrcM),
        .WA3W(WA3W), .RegWriteW(RegWriteW), .MemToRegW(MemToRegW), .PCSrcW(PCSrcW)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    wire [28:0] dut_o = {RA1E, RA2E, WA3E, MemToRegE, PCSrcE, BranchTakenE,
                         WA3M, RegWriteM, PCSrcM, WA3W, RegWriteW, MemToRegW, PCSrcW};

    // ARM condition table over an NZCV nibble.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic nf, zf, cf, vf;
        {nf, zf, cf, vf} = f;
        case (cond)
            4'h0: return zf;
            4'h1: return !zf;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return nf;
            4'h5: return !nf;
            4'h6: return vf;
            4'h7: return !vf;
            4'h8: return cf && !zf;
            4'h9: return !cf || zf;
            4'hA: return nf == vf;
            4'hB: return nf != vf;
            4'hC: return !zf && nf == vf;
            4'hD: return zf || nf != vf;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [28:0] model_out();
        logic ok;
        ok = cond_pass(me.cond, mf);
        return {me.ra1, me.ra2, me.wa3, me.mtr, me.pcs & ok, me.br & ok,
                mm.wa3, mm.rw, mm.pcs, mw.wa3, mw.rw, mw.mtr, mw.pcs};
    endfunction

    function automatic inst_t mk(input logic [3:0] ra1, input logic [3:0] wa3, input logic rw,
                                 input logic pcs, input logic br, input logic [1:0] fw, input logic [3:0] cond);
        inst_t r;
        r = '{ra1: ra1, ra2: 4'h3, wa3: wa3, rw: rw, mtr: 1'b0, pcs: pcs, br: br, fw: fw, cond: cond};
        return r;
    endfunction

    function automatic inst_t rnd_inst();
        logic [31:0] x;
        x = $urandom;
        return inst_t'(x[$bits(inst_t)-1:0]);
    endfunction

    task automatic step(input inst_t d, input logic fl, input logic [3:0] alu, input logic rs);
        logic ok;
        {RA1D, RA2D, WA3D, RegWriteD, MemToRegD, PCSrcD, BranchD, FlagWriteD, CondD} = d;
        FlushE = fl;
        ALUFlagsE = alu;
        Reset = rs;
        @(posedge Clk);
        if (rs) begin
            me = '0; mm = '0; mw = '0; mf = 4'b0000;
        end else begin
            ok = cond_pass(me.cond, mf);
            mw = mm;
            mm = '{wa3: me.wa3, rw: me.rw & ok, mtr: me.mtr & ok, pcs: me.pcs & ok};
            if (ok && me.fw[1]) mf[3:2] = alu[3:2];
            if (ok && me.fw[0]) mf[1:0] = alu[1:0];
            me = fl ? '0 : d;
        end
        @(negedge Clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(rnd_inst(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b1);
            n_vec++;
            if (dut_o !== 29'd0) begin
                n_bad++;
                $display("FAIL reset_outputs cycle %0d: got %h expected 0", i, dut_o);
            end
        end
        step(mk(4'h1, 4'h0, 1'b0, 1'b0, 1'b1, 2'b00, 4'h0), 1'b0, 4'hF, 1'b0);
        n_vec++;
        if (BranchTakenE !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags_eq: BranchTakenE got %b expected 0", BranchTakenE);
        end
        step(mk(4'h1, 4'h0, 1'b0, 1'b0, 1'b1, 2'b00, 4'h1), 1'b0, 4'hF, 1'b0);
        n_vec++;
        if (BranchTakenE !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_flags_ne: BranchTakenE got %b expected 1", BranchTakenE);
        end
    endtask

    task automatic test_cond_regwrite();
        step(mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'b10, 4'hE), 1'b0, 4'h0, 1'b0);
        step(mk(4'h0, 4'h5, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0), 1'b0, 4'b0100, 1'b0);
        step(mk(4'h0, 4'h6, 1'b1, 1'b0, 1'b0, 2'b00, 4'h1), 1'b0, 4'h0, 1'b0);
        n_vec++;
        if ({RegWriteM, WA3M} !== {1'b1, 4'h5}) begin
            n_bad++;
            $display("FAIL eq_regwrite_m: RegWriteM/WA3M got %b/%h expected 1/5", RegWriteM, WA3M);
        end
        step('0, 1'b0, 4'h0, 1'b0);
        n_vec++;
        if ({RegWriteW, WA3W} !== {1'b1, 4'h5}) begin
            n_bad++;
            $display("FAIL eq_regwrite_w: RegWriteW/WA3W got %b/%h expected 1/5", RegWriteW, WA3W);
        end
        n_vec++;
        if ({RegWriteM, WA3M} !== {1'b0, 4'h6}) begin
            n_bad++;
            $display("FAIL ne_squash_m: RegWriteM/WA3M got %b/%h expected 0/6", RegWriteM, WA3M);
        end
        step('0, 1'b0, 4'h0, 1'b0);
        n_vec++;
        if (RegWriteW !== 1'b0) begin
            n_bad++;
            $display("FAIL ne_squash_w: RegWriteW got %b expected 0", RegWriteW);
        end
    endtask

    task automatic test_branch_flush();
        step(mk(4'h7, 4'h0, 1'b0, 1'b0, 1'b1, 2'b00, 4'hE), 1'b0, 4'h0, 1'b0);
        n_vec++;
        if ({RA1E, BranchTakenE} !== {4'h7, 1'b1}) begin
            n_bad++;
            $display("FAIL branch_al: RA1E/BranchTakenE got %h/%b expected 7/1", RA1E, BranchTakenE);
        end
        step(mk(4'h7, 4'h0, 1'b0, 1'b0, 1'b1, 2'b00, 4'hE), 1'b1, 4'h0, 1'b0);
        n_vec++;
        if ({RA1E, RA2E, BranchTakenE} !== {4'h0, 4'h0, 1'b0}) begin
            n_bad++;
            $display("FAIL branch_flush: RA1E/RA2E/BranchTakenE got %h/%h/%b expected 0/0/0", RA1E, RA2E, BranchTakenE);
        end
        step('0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic test_flags_cond();
        logic [3:0] conds [3] = '{4'hB, 4'hC, 4'hD};
        step(mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'b11, 4'hE), 1'b0, 4'h0, 1'b0);
        step(mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 2'b00, conds[0]), 1'b0, 4'b1001, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step(mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 2'b00, conds[i]), 1'b0, 4'h0, 1'b0);
            n_vec++;
            if (BranchTakenE !== cond_pass(conds[i], 4'b1001)) begin
                n_bad++;
                $display("FAIL flags_cond_%h: BranchTakenE got %b expected %b", conds[i], BranchTakenE,
                         cond_pass(conds[i], 4'b1001));
            end
        end
    endtask

    task automatic test_undefined();
        step(mk(4'h0, 4'h9, 1'b1, 1'b1, 1'b0, 2'b11, 4'hF), 1'b0, 4'h0, 1'b0);
        n_vec++;
        if (PCSrcE !== 1'b0) begin
            n_bad++;
            $display("FAIL undef_pcsrc_e: got %b expected 0", PCSrcE);
        end
        step(mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 2'b00, 4'h0), 1'b0, 4'b1111, 1'b0);
        n_vec++;
        if ({RegWriteM, PCSrcM} !== 2'b00) begin
            n_bad++;
            $display("FAIL undef_m: RegWriteM/PCSrcM got %b/%b expected 0/0", RegWriteM, PCSrcM);
        end
        n_vec++;
        if (BranchTakenE !== cond_pass(4'h0, 4'b1001)) begin
            n_bad++;
            $display("FAIL undef_flags_z: BranchTakenE got %b expected %b", BranchTakenE, cond_pass(4'h0, 4'b1001));
        end
        step(mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 2'b00, 4'h3), 1'b0, 4'h0, 1'b0);
        n_vec++;
        if (PCSrcW !== 1'b0) begin
            n_bad++;
            $display("FAIL undef_pcsrc_w: got %b expected 0", PCSrcW);
        end
        n_vec++;
        if (BranchTakenE !== cond_pass(4'h3, 4'b1001)) begin
            n_bad++;
            $display("FAIL undef_flags_c: BranchTakenE got %b expected %b", BranchTakenE, cond_pass(4'h3, 4'b1001));
        end
    endtask

    task automatic test_reset_mid();
        step(mk(4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 2'b00, 4'hE), 1'b0, 4'h0, 1'b0);
        n_vec++;
        if (PCSrcE !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_pcsrc_e: got %b expected 1", PCSrcE);
        end
        step('0, 1'b0, 4'h0, 1'b0);
        n_vec++;
        if (PCSrcM !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_pcsrc_m: got %b expected 1", PCSrcM);
        end
        step('0, 1'b0, 4'h0, 1'b1);
        n_vec++;
        if (dut_o !== 29'd0) begin
            n_bad++;
            $display("FAIL mid_reset_all: got %h expected 0", dut_o);
        end
        for (int i = 0; i < 2; i++) begin
            step('0, 1'b0, 4'h0, 1'b0);
            n_vec++;
            if (PCSrcW !== 1'b0) begin
                n_bad++;
                $display("FAIL mid_residue cycle %0d: PCSrcW got %b expected 0", i, PCSrcW);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(rnd_inst(), $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)), $urandom_range(0, 49) == 0);
            n_vec++;
            if (dut_o !== model_out()) begin
                n_bad++;
                $display("FAIL random cycle %0d: got %h expected %h", i, dut_o, model_out());
            end
        end
    endtask

    initial begin
        me = '0; mm = '0; mw = '0; mf = 4'b0000;
        test_reset();
        test_cond_regwrite();
        test_branch_flush();
        test_flags_cond();
        test_undefined();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
